// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Results appear on sum/cout WIDTH cycles after start is accepted.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | shifting operands through the full adder, one bit per cycle

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_shift;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               done_q;
    logic               accept;
    logic               last;
    logic               s_bit;
    logic               c_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (cnt_q == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // New bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub | cin;
                res_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == ADD) begin
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                carry_q <= c_next;
                res_q   <= res_shift;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last) begin
                    sum_q  <= res_shift;
                    cout_q <= c_next;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == ADD);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
